// File: rtl/ex_mem_pipe_pkg.sv
// Shared constants and state encoding for the EX->MEM pipeline register.
package ex_mem_pipe_pkg;

   // Register address 0 doubles as the "no destination" marker.
   localparam logic [4:0]  NopRegAddr   = 5'd0;
   localparam logic [31:0] ZeroWord     = 32'h0000_0000;
   localparam logic        WriteEnable  = 1'b1;
   localparam logic        WriteDisable = 1'b0;

   // Memory-access op codes carried to MEM.
   localparam logic [7:0] AluOpNop = 8'h00;
   localparam logic [7:0] AluOpLb  = 8'h20;
   localparam logic [7:0] AluOpLh  = 8'h21;
   localparam logic [7:0] AluOpLw  = 8'h23;
   localparam logic [7:0] AluOpSb  = 8'h28;
   localparam logic [7:0] AluOpSh  = 8'h29;
   localparam logic [7:0] AluOpSw  = 8'h2b;

   // Occupancy of the skid buffer.
   typedef enum logic [1:0] {
      StEmpty = 2'b00,
      StFull  = 2'b01,
      StSkid  = 2'b10
   } pipe_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic width-W valid/ready register stage with a 2-entry skid buffer.
// in_ready is a flop, so there is no combinational path from out_ready to in_ready.
module pipe_skid_buf
   import ex_mem_pipe_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic [W-1:0] clr_mask,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   pipe_state_e  state_q, state_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         in_ready_q;
   logic         in_fire;

   assign in_ready  = in_ready_q;
   assign in_fire   = in_valid & in_ready_q;
   assign out_valid = (state_q != StEmpty);
   assign out_data  = main_q;

   // Next-state and register-load decisions; main only moves when MEM takes it or stage is empty.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // Anything arriving this cycle is dropped; clr_mask bits are zeroed on the way to empty.
         state_d = StEmpty;
         main_d  = main_q & ~clr_mask;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (in_fire) begin
                  state_d = StFull;
                  main_d  = in_data;
               end
            end
            StFull: begin
               if (in_fire && out_ready) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  state_d = StSkid;
                  skid_d  = in_data;
               end else if (out_ready) begin
                  state_d = StEmpty;
                  main_d  = main_q & ~clr_mask;
               end
            end
            StSkid: begin
               if (out_ready) begin
                  state_d = StFull;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = StEmpty;
            end
         endcase
      end
   end

   // State, payload and registered in_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StEmpty;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= (state_d != StSkid);
      end
   end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with valid/ready handshake, skid buffering, flush and a
// saturating stall-cycle counter.
module ex_mem_pipe
   import ex_mem_pipe_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned ALUOP_W    = 8,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [REG_ADDR_W-1:0] ex_wd,
   input  logic                  ex_wreg,
   input  logic [DATA_W-1:0]     ex_wdata,
   input  logic [ALUOP_W-1:0]    ex_aluop,
   input  logic [DATA_W-1:0]     ex_mem_addr,
   input  logic [DATA_W-1:0]     ex_store_data,
   input  logic                  ex_whilo,
   input  logic [DATA_W-1:0]     ex_hi,
   input  logic [DATA_W-1:0]     ex_lo,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [REG_ADDR_W-1:0] mem_wd,
   output logic                  mem_wreg,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [ALUOP_W-1:0]    mem_aluop,
   output logic [DATA_W-1:0]     mem_mem_addr,
   output logic [DATA_W-1:0]     mem_store_data,
   output logic                  mem_whilo,
   output logic [DATA_W-1:0]     mem_hi,
   output logic [DATA_W-1:0]     mem_lo,
   output logic [CNT_W-1:0]      stall_cycles
);

   // Payload layout, LSB first: lo, hi, whilo, store_data, mem_addr, aluop, wdata, wreg, wd.
   localparam int unsigned LoLsb    = 0;
   localparam int unsigned HiLsb    = DATA_W;
   localparam int unsigned WhiloBit = 2 * DATA_W;
   localparam int unsigned StoreLsb = 2 * DATA_W + 1;
   localparam int unsigned AddrLsb  = 3 * DATA_W + 1;
   localparam int unsigned AluopLsb = 4 * DATA_W + 1;
   localparam int unsigned WdataLsb = 4 * DATA_W + 1 + ALUOP_W;
   localparam int unsigned WregBit  = 5 * DATA_W + 1 + ALUOP_W;
   localparam int unsigned WdLsb    = WregBit + 1;
   localparam int unsigned PayloadW = WdLsb + REG_ADDR_W;

   // Write enables are the only fields that must read as inactive once the stage empties.
   localparam logic [PayloadW-1:0] ClrMask =
      (PayloadW'(1) << WregBit) | (PayloadW'(1) << WhiloBit);

   logic [PayloadW-1:0] in_payload;
   logic [PayloadW-1:0] out_payload;
   logic [CNT_W-1:0]    stall_q;

   assign in_payload = {ex_wd, ex_wreg, ex_wdata, ex_aluop, ex_mem_addr, ex_store_data,
                        ex_whilo, ex_hi, ex_lo};

   pipe_skid_buf #(
      .W (PayloadW)
   ) u_skid_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .clr_mask  (ClrMask),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_payload),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_payload)
   );

   assign mem_wd         = out_payload[WdLsb +: REG_ADDR_W];
   assign mem_wreg       = out_payload[WregBit];
   assign mem_wdata      = out_payload[WdataLsb +: DATA_W];
   assign mem_aluop      = out_payload[AluopLsb +: ALUOP_W];
   assign mem_mem_addr   = out_payload[AddrLsb +: DATA_W];
   assign mem_store_data = out_payload[StoreLsb +: DATA_W];
   assign mem_whilo      = out_payload[WhiloBit];
   assign mem_hi         = out_payload[HiLsb +: DATA_W];
   assign mem_lo         = out_payload[LoLsb +: DATA_W];

   // Count back-pressured cycles, saturating; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_q <= stall_q + CNT_W'(1);
      end
   end

   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: directed scenarios plus a randomized run against a
// queue-based reference model.
module tb_ex_mem_pipe;

   typedef struct packed {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic [7:0]  aluop;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
   } pl_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   pl_t        drv = '0;
   pl_t        got;
   logic       in_ready;
   logic       out_valid;
   logic [3:0] stall_cycles;

   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic [7:0]  mem_aluop;
   logic [31:0] mem_mem_addr;
   logic [31:0] mem_store_data;
   logic        mem_whilo;
   logic [31:0] mem_hi;
   logic [31:0] mem_lo;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ex_mem_pipe #(
      .DATA_W     (32),
      .REG_ADDR_W (5),
      .ALUOP_W    (8),
      .CNT_W      (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .ex_wd          (drv.wd),
      .ex_wreg        (drv.wreg),
      .ex_wdata       (drv.wdata),
      .ex_aluop       (drv.aluop),
      .ex_mem_addr    (drv.addr),
      .ex_store_data  (drv.sdata),
      .ex_whilo       (drv.whilo),
      .ex_hi          (drv.hi),
      .ex_lo          (drv.lo),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .mem_wd         (mem_wd),
      .mem_wreg       (mem_wreg),
      .mem_wdata      (mem_wdata),
      .mem_aluop      (mem_aluop),
      .mem_mem_addr   (mem_mem_addr),
      .mem_store_data (mem_store_data),
      .mem_whilo      (mem_whilo),
      .mem_hi         (mem_hi),
      .mem_lo         (mem_lo),
      .stall_cycles   (stall_cycles)
   );

   assign got = '{wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata, aluop: mem_aluop,
                  addr: mem_mem_addr, sdata: mem_store_data, whilo: mem_whilo,
                  hi: mem_hi, lo: mem_lo};

   // Reference model: a FIFO of at most two instructions, in_ready = room left after the cycle.
   pl_t mq[$];
   int  m_stall = 0;
   bit  m_in_ready = 1'b1;
   bit  m_ofire;
   bit  m_ifire;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_stall    = 0;
         m_in_ready = 1'b1;
      end else begin
         m_ofire = (mq.size() > 0) && out_ready;
         m_ifire = in_valid && m_in_ready;
         if ((mq.size() > 0) && !out_ready && (m_stall < 15)) m_stall++;
         if (m_ofire) void'(mq.pop_front());
         if (flush) mq.delete();
         else if (m_ifire) mq.push_back(drv);
         m_in_ready = (mq.size() < 2);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [4:0] wd, input logic [31:0] wdata);
      in_valid    = v;
      drv         = '0;
      drv.wd      = wd;
      drv.wreg    = 1'b1;
      drv.wdata   = wdata;
      drv.aluop   = 8'h23;
      drv.addr    = wdata + 32'h100;
      drv.sdata   = ~wdata;
      drv.whilo   = 1'b1;
      drv.hi      = {wdata[15:0], 16'h0};
      drv.lo      = wdata ^ 32'h5a5a;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(1'b1, 5'd7, 32'hdead_beef);
      out_ready = 1'b0;
      step();
      step();
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      tests++;
      if (in_ready !== 1'b1) begin
         fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      tests++;
      if (mem_wd !== 5'd0 || mem_wreg !== 1'b0) begin
         fails++; $display("FAIL reset_wd_wreg: got %0d/%b want 0/0", mem_wd, mem_wreg);
      end
      tests++;
      if (stall_cycles !== 4'd0) begin
         fails++; $display("FAIL reset_stall: got %0d want 0", stall_cycles);
      end
      tests++;
      if (got !== pl_t'(0)) begin
         fails++; $display("FAIL reset_payload: got %h want 0", got);
      end
      rst = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic test_streaming();
      logic [31:0] vals [3];
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 5'(3 + i), vals[i]);
         step();
         tests++;
         if (out_valid !== 1'b1 || mem_wd !== 5'(3 + i) || mem_wdata !== vals[i]) begin
            fails++;
            $display("FAIL stream_%0d: got v=%b wd=%0d wdata=%h want v=1 wd=%0d wdata=%h",
                     i, out_valid, mem_wd, mem_wdata, 3 + i, vals[i]);
         end
      end
      in_valid = 1'b0;
      step();
      tests++;
      if (out_valid !== 1'b0 || mem_wreg !== 1'b0 || mem_whilo !== 1'b0) begin
         fails++;
         $display("FAIL stream_drain: got v=%b wreg=%b whilo=%b want 0/0/0",
                  out_valid, mem_wreg, mem_whilo);
      end
   endtask

   task automatic test_back_pressure();
      out_ready = 1'b0;
      set_in(1'b1, 5'd1, 32'hA);
      step();
      set_in(1'b1, 5'd2, 32'hB);
      step();
      in_valid = 1'b0;
      tests++;
      if (in_ready !== 1'b0 || mem_wdata !== 32'hA || stall_cycles !== 4'd1) begin
         fails++;
         $display("FAIL bp_skid: got rdy=%b wdata=%h stall=%0d want 0/a/1",
                  in_ready, mem_wdata, stall_cycles);
      end
      for (int i = 2; i <= 3; i++) begin
         step();
         tests++;
         if (mem_wdata !== 32'hA || stall_cycles !== 4'(i) || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_hold_%0d: got wdata=%h stall=%0d v=%b want a/%0d/1",
                     i, mem_wdata, stall_cycles, out_valid, i);
         end
      end
      out_ready = 1'b1;
      #1;
      tests++;
      if (mem_wdata !== 32'hA) begin
         fails++; $display("FAIL bp_first: got %h want a", mem_wdata);
      end
      step();
      tests++;
      if (out_valid !== 1'b1 || mem_wdata !== 32'hB || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp_second: got v=%b wdata=%h rdy=%b want 1/b/1",
                  out_valid, mem_wdata, in_ready);
      end
      step();
      tests++;
      if (out_valid !== 1'b0 || stall_cycles !== 4'd3) begin
         fails++;
         $display("FAIL bp_empty: got v=%b stall=%0d want 0/3", out_valid, stall_cycles);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      set_in(1'b1, 5'd8, 32'hD);
      step();
      set_in(1'b1, 5'd9, 32'hE);
      step();
      flush = 1'b1;
      set_in(1'b1, 5'd10, 32'hC);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || mem_wreg !== 1'b0 || mem_whilo !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL flush_skid: got v=%b wreg=%b whilo=%b rdy=%b want 0/0/0/1",
                  out_valid, mem_wreg, mem_whilo, in_ready);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         tests++;
         if (out_valid !== 1'b0) begin
            fails++; $display("FAIL flush_no_c_%0d: got v=%b wdata=%h want v=0",
                              i, out_valid, mem_wdata);
         end
      end
      // Flush from FULL with a concurrent accepted input: the input must be discarded.
      out_ready = 1'b0;
      set_in(1'b1, 5'd11, 32'hF);
      step();
      flush = 1'b1;
      set_in(1'b1, 5'd12, 32'h12);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      step();
      tests++;
      if (out_valid !== 1'b0 || mem_wreg !== 1'b0) begin
         fails++; $display("FAIL flush_full: got v=%b wreg=%b want 0/0", out_valid, mem_wreg);
      end
   endtask

   task automatic test_saturation();
      out_ready = 1'b0;
      set_in(1'b1, 5'd13, 32'h77);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) step();
      tests++;
      if (stall_cycles !== 4'd15 || out_valid !== 1'b1) begin
         fails++;
         $display("FAIL sat_value: got stall=%0d v=%b want 15/1", stall_cycles, out_valid);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      tests++;
      if (stall_cycles !== 4'd15) begin
         fails++; $display("FAIL sat_flush_keeps: got %0d want 15", stall_cycles);
      end
   endtask

   task automatic test_reset_in_skid();
      out_ready = 1'b0;
      set_in(1'b1, 5'd14, 32'h1);
      step();
      set_in(1'b1, 5'd15, 32'h2);
      step();
      in_valid = 1'b0;
      tests++;
      if (in_ready !== 1'b0) begin
         fails++; $display("FAIL rskid_pre: got rdy=%b want 0", in_ready);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cycles !== 4'd0 || got !== pl_t'(0)) begin
         fails++;
         $display("FAIL rskid_reset: got v=%b rdy=%b stall=%0d pl=%h want 0/1/0/0",
                  out_valid, in_ready, stall_cycles, got);
      end
      out_ready = 1'b1;
      set_in(1'b1, 5'd6, 32'h5);
      step();
      in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b1 || mem_wdata !== 32'h5 || mem_wd !== 5'd6) begin
         fails++;
         $display("FAIL rskid_after: got v=%b wdata=%h wd=%0d want 1/5/6",
                  out_valid, mem_wdata, mem_wd);
      end
      step();
   endtask

   task automatic test_random();
      pl_t p;
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 99) < 2);
         flush     = ($urandom_range(0, 99) < 5);
         in_valid  = ($urandom_range(0, 99) < 65);
         out_ready = ($urandom_range(0, 99) < 55);
         p.wd    = 5'($urandom);
         p.wreg  = 1'($urandom);
         p.wdata = $urandom;
         p.aluop = 8'($urandom);
         p.addr  = $urandom;
         p.sdata = $urandom;
         p.whilo = 1'($urandom);
         p.hi    = $urandom;
         p.lo    = $urandom;
         drv     = p;
         step();
         tests++;
         if (out_valid !== (mq.size() > 0) || in_ready !== m_in_ready ||
             stall_cycles !== 4'(m_stall)) begin
            fails++;
            $display("FAIL rand_ctrl_%0d: got v=%b rdy=%b stall=%0d want v=%b rdy=%b stall=%0d",
                     i, out_valid, in_ready, stall_cycles, mq.size() > 0, m_in_ready, m_stall);
         end
         tests++;
         if (mq.size() > 0) begin
            if (got !== mq[0]) begin
               fails++;
               $display("FAIL rand_payload_%0d: got %h want %h", i, got, mq[0]);
            end
         end else if (mem_wreg !== 1'b0 || mem_whilo !== 1'b0) begin
            fails++;
            $display("FAIL rand_empty_we_%0d: got wreg=%b whilo=%b want 0/0",
                     i, mem_wreg, mem_whilo);
         end
      end
      rst = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_back_pressure();
      test_flush();
      test_saturation();
      test_reset_in_skid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
